// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO arbiter: FIFO address codes,
// channel indices and the bus sequencing state encoding.
package fx2_pkg;

   localparam logic [1:0] ADR_FIFO2 = 2'b00;
   localparam logic [1:0] ADR_FIFO4 = 2'b10;
   localparam logic [1:0] ADR_FIFO5 = 2'b11;

   localparam logic [1:0] CH_RD  = 2'd0;
   localparam logic [1:0] CH_WR0 = 2'd1;
   localparam logic [1:0] CH_WR1 = 2'd2;

   typedef enum logic [1:0] {
      SETUP  = 2'd0,
      XFER   = 2'd1,
      PKTEND = 2'd2,
      TURN   = 2'd3
   } arb_state_t;

   function automatic logic [1:0] chan_adr(input logic [1:0] ch);
      case (ch)
         CH_WR0:  return ADR_FIFO4;
         CH_WR1:  return ADR_FIFO5;
         default: return ADR_FIFO2;
      endcase
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over three channels (0 -> 1 -> 2 -> 0),
// starting the search at the channel after the current owner.
module rr_pick3
   import fx2_pkg::*;
(
   input  logic [2:0] elig,
   input  logic [1:0] cur,
   output logic [1:0] nxt,
   output logic       any_other
);

   logic [1:0] c1;
   logic [1:0] c2;

   always_comb begin
      case (cur)
         CH_WR0:  begin c1 = CH_WR1; c2 = CH_RD;  end
         CH_WR1:  begin c1 = CH_RD;  c2 = CH_WR0; end
         default: begin c1 = CH_WR0; c2 = CH_WR1; end
      endcase
      any_other = elig[c1] | elig[c2];
      nxt       = cur;
      if (elig[c1])      nxt = c1;
      else if (elig[c2]) nxt = c2;
   end

endmodule

// File: rtl/fx2_fifo_arbiter.sv
// Sequences the shared FX2 slave-FIFO bus between the FIFO2 command reader
// and the FIFO4/FIFO5 writers with turnaround, burst limiting and PKTEND.
module fx2_fifo_arbiter
   import fx2_pkg::*;
#(
   parameter int unsigned MAX_BURST = 64,
   parameter int unsigned BURST_W   = 7
)(
   input  logic       FIFO_clk,
   input  logic       reset,
   input  logic       fifo2_empty,
   input  logic       fifo4_full,
   input  logic       fifo5_full,
   input  logic [7:0] FIFO_DATAIN,
   output logic [7:0] FIFO_DATAOUT,
   output logic       FIFO_DATAOUT_OE,
   output logic       FIFO_RD,
   output logic       FIFO_WR,
   output logic       FIFO_PKTEND,
   output logic [1:0] FIFO_FIFOADR,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic       rd_strobe,
   input  logic [1:0] wr_valid,
   input  logic [7:0] wr_data0,
   input  logic [7:0] wr_data1,
   output logic [1:0] wr_ready,
   input  logic [1:0] pktend_req,
   output logic [1:0] pktend_ack,
   output logic [1:0] grant
);

   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   arb_state_t         state, state_nx;
   logic [1:0]         owner, pend_owner, pick;
   logic [BURST_W-1:0] burst_cnt, burst_inc;
   logic [2:0]         elig;
   logic [1:0]         wr_go;
   logic               rd_go, any_other, is_wr, wch, xfer, at_limit;

   assign wr_go = wr_valid & ~{fifo5_full, fifo4_full};
   assign rd_go = rd_ready & ~fifo2_empty;
   assign elig  = {wr_go[1] | pktend_req[1], wr_go[0] | pktend_req[0], rd_go};
   assign is_wr = (owner != CH_RD);
   assign wch   = (owner == CH_WR1);

   assign grant        = owner;
   assign FIFO_FIFOADR = chan_adr(owner);
   assign FIFO_DATAOUT = (owner == CH_WR1) ? wr_data1 :
                         (owner == CH_WR0) ? wr_data0 : '0;

   rr_pick3 u_pick (
      .elig      (elig),
      .cur       (owner),
      .nxt       (pick),
      .any_other (any_other)
   );

   // The limit test includes this cycle's transfer so the last burst strobe
   // is followed directly by TURN, keeping the penalty at two bus cycles.
   assign burst_inc = burst_cnt + BURST_W'(xfer);
   assign at_limit  = (burst_inc == BURST_MAX);

   always_comb begin
      state_nx        = state;
      FIFO_RD         = 1'b0;
      FIFO_WR         = 1'b0;
      FIFO_PKTEND     = 1'b0;
      FIFO_DATAOUT_OE = 1'b0;
      wr_ready        = '0;
      pktend_ack      = '0;
      xfer            = 1'b0;
      case (state)
         SETUP: begin
            FIFO_DATAOUT_OE = is_wr;
            state_nx        = XFER;
         end
         XFER: begin
            FIFO_DATAOUT_OE = is_wr;
            if (is_wr) begin
               FIFO_WR       = wr_go[wch];
               wr_ready[wch] = wr_go[wch];
               xfer          = wr_go[wch];
            end else begin
               FIFO_RD = rd_go;
               xfer    = rd_go;
            end
            if (is_wr && pktend_req[wch] && !wr_valid[wch])
               state_nx = PKTEND;
            else if (any_other && (!elig[owner] || at_limit))
               state_nx = TURN;
         end
         PKTEND: begin
            FIFO_DATAOUT_OE = 1'b1;
            FIFO_PKTEND     = 1'b1;
            pktend_ack[wch] = 1'b1;
            state_nx        = XFER;
         end
         TURN: state_nx = SETUP;
         default: state_nx = SETUP;
      endcase
   end

   always_ff @(posedge FIFO_clk or posedge reset) begin
      if (reset) begin
         state      <= SETUP;
         owner      <= CH_RD;
         pend_owner <= CH_RD;
         burst_cnt  <= '0;
         rd_data    <= '0;
         rd_strobe  <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_strobe <= FIFO_RD;
         if (FIFO_RD) rd_data <= FIFO_DATAIN;
         case (state)
            XFER: begin
               if (state_nx == TURN) begin
                  pend_owner <= pick;
                  burst_cnt  <= burst_inc;
               end else if (at_limit) begin
                  burst_cnt <= '0;
               end else begin
                  burst_cnt <= burst_inc;
               end
            end
            TURN: begin
               owner     <= pend_owner;
               burst_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Directed bench for fx2_fifo_arbiter: per-cycle vector table plus
// sequences for burst alternation, saturation and mid-burst reset.
module tb_fx2_fifo_arbiter;

   logic       FIFO_clk = 1'b0;
   logic       reset;
   logic       fifo2_empty, fifo4_full, fifo5_full;
   logic [7:0] FIFO_DATAIN, FIFO_DATAOUT;
   logic       FIFO_DATAOUT_OE, FIFO_RD, FIFO_WR, FIFO_PKTEND;
   logic [1:0] FIFO_FIFOADR;
   logic       rd_ready, rd_strobe;
   logic [7:0] rd_data;
   logic [1:0] wr_valid, wr_ready, pktend_req, pktend_ack, grant;
   logic [7:0] wr_data0, wr_data1;

   int passed = 0;
   int total  = 0;

   always #5 FIFO_clk = ~FIFO_clk;

   fx2_fifo_arbiter #(.MAX_BURST(64), .BURST_W(7)) dut (
      .FIFO_clk        (FIFO_clk),
      .reset           (reset),
      .fifo2_empty     (fifo2_empty),
      .fifo4_full      (fifo4_full),
      .fifo5_full      (fifo5_full),
      .FIFO_DATAIN     (FIFO_DATAIN),
      .FIFO_DATAOUT    (FIFO_DATAOUT),
      .FIFO_DATAOUT_OE (FIFO_DATAOUT_OE),
      .FIFO_RD         (FIFO_RD),
      .FIFO_WR         (FIFO_WR),
      .FIFO_PKTEND     (FIFO_PKTEND),
      .FIFO_FIFOADR    (FIFO_FIFOADR),
      .rd_ready        (rd_ready),
      .rd_data         (rd_data),
      .rd_strobe       (rd_strobe),
      .wr_valid        (wr_valid),
      .wr_data0        (wr_data0),
      .wr_data1        (wr_data1),
      .wr_ready        (wr_ready),
      .pktend_req      (pktend_req),
      .pktend_ack      (pktend_ack),
      .grant           (grant)
   );

   typedef struct {
      logic [1:0] wv;
      logic       f4, f5, rr, e2;
      logic [1:0] pr;
      logic [7:0] d0, d1, din;
      logic [28:0] exp_v;
   } vec_t;

   vec_t q[$];
   vec_t cur;

   // {adr, oe, rd, wr, pktend, ack, wr_ready, grant, dataout, rd_strobe, rd_data}
   function automatic logic [28:0] act_vec();
      return {FIFO_FIFOADR, FIFO_DATAOUT_OE, FIFO_RD, FIFO_WR, FIFO_PKTEND,
              pktend_ack, wr_ready, grant, FIFO_DATAOUT, rd_strobe, rd_data};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic ex(input logic [1:0] adr, input logic oe, input logic rd, input logic wr,
                     input logic pk, input logic [1:0] ack, input logic [1:0] wrdy,
                     input logic [1:0] gnt, input logic [7:0] dout, input logic rs,
                     input logic [7:0] rdat);
      cur.exp_v = {adr, oe, rd, wr, pk, ack, wrdy, gnt, dout, rs, rdat};
      q.push_back(cur);
   endtask

   task automatic apply(input vec_t v);
      wr_valid    = v.wv;
      fifo4_full  = v.f4;
      fifo5_full  = v.f5;
      rd_ready    = v.rr;
      fifo2_empty = v.e2;
      pktend_req  = v.pr;
      wr_data0    = v.d0;
      wr_data1    = v.d1;
      FIFO_DATAIN = v.din;
   endtask

   initial begin
      int nruns, idle, dbad, wrcnt, waited;
      int run_len[4];
      int gap_before[4];
      logic [1:0] run_adr[4];
      logic [1:0] prev_adr;
      logic prev_wr, found;
      logic [4:0] wr_pat;
      logic [1:0] gnt3;

      // ---- vector table ----
      cur = '{wv: 2'b01, f4: 0, f5: 0, rr: 0, e2: 1, pr: 2'b00,
              d0: 8'h10, d1: 8'h55, din: 8'h00, exp_v: '0};
      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h00);  // SETUP, owner read
      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h00);  // XFER, decide switch
      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h00);  // TURN
      ex(2'b10,1,0,0,0,2'b00,2'b00,2'd1,8'h10,0,8'h00);  // SETUP FIFO4
      ex(2'b10,1,0,1,0,2'b00,2'b01,2'd1,8'h10,0,8'h00);
      cur.d0 = 8'h11; ex(2'b10,1,0,1,0,2'b00,2'b01,2'd1,8'h11,0,8'h00);
      cur.d0 = 8'h12; ex(2'b10,1,0,1,0,2'b00,2'b01,2'd1,8'h12,0,8'h00);
      cur.d0 = 8'h13; cur.f4 = 1;
      for (int k = 0; k < 5; k++) ex(2'b10,1,0,0,0,2'b00,2'b00,2'd1,8'h13,0,8'h00);
      cur.f4 = 0;     ex(2'b10,1,0,1,0,2'b00,2'b01,2'd1,8'h13,0,8'h00);
      cur.wv = 2'b00; ex(2'b10,1,0,0,0,2'b00,2'b00,2'd1,8'h13,0,8'h00);
      cur.wv = 2'b10; ex(2'b10,1,0,0,0,2'b00,2'b00,2'd1,8'h13,0,8'h00);
      ex(2'b10,0,0,0,0,2'b00,2'b00,2'd1,8'h13,0,8'h00);  // TURN
      ex(2'b11,1,0,0,0,2'b00,2'b00,2'd2,8'h55,0,8'h00);  // SETUP FIFO5
      ex(2'b11,1,0,1,0,2'b00,2'b10,2'd2,8'h55,0,8'h00);
      cur.d1 = 8'h56; cur.pr = 2'b10;
      ex(2'b11,1,0,1,0,2'b00,2'b10,2'd2,8'h56,0,8'h00);
      cur.d1 = 8'h57; ex(2'b11,1,0,1,0,2'b00,2'b10,2'd2,8'h57,0,8'h00);
      cur.wv = 2'b00; ex(2'b11,1,0,0,0,2'b00,2'b00,2'd2,8'h57,0,8'h00);
      ex(2'b11,1,0,0,1,2'b10,2'b00,2'd2,8'h57,0,8'h00);  // PKTEND
      cur.pr = 2'b00; ex(2'b11,1,0,0,0,2'b00,2'b00,2'd2,8'h57,0,8'h00);
      cur.rr = 1; cur.e2 = 0; cur.din = 8'hA5;
      ex(2'b11,1,0,0,0,2'b00,2'b00,2'd2,8'h57,0,8'h00);
      ex(2'b11,0,0,0,0,2'b00,2'b00,2'd2,8'h57,0,8'h00);  // TURN
      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h00);  // SETUP FIFO2
      ex(2'b00,0,1,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h00);
      cur.din = 8'h3C; ex(2'b00,0,1,0,0,2'b00,2'b00,2'd0,8'h00,1,8'hA5);
      cur.e2 = 1;      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,1,8'h3C);
      ex(2'b00,0,0,0,0,2'b00,2'b00,2'd0,8'h00,0,8'h3C);

      // ---- reset state ----
      reset = 1'b1;
      apply('{wv: 2'b00, f4: 0, f5: 0, rr: 0, e2: 1, pr: 2'b00,
              d0: 8'h00, d1: 8'h00, din: 8'h00, exp_v: '0});
      #2;
      check("reset_outputs", 32'(act_vec()), 32'd0);
      repeat (2) @(negedge FIFO_clk);
      reset = 1'b0;

      for (int i = 0; i < q.size(); i++) begin
         apply(q[i]);
         #1;
         check($sformatf("vec%0d", i), 32'(act_vec()), 32'(q[i].exp_v));
         @(negedge FIFO_clk);
      end

      // ---- both writers streaming: 64-transfer bursts, 2-cycle gaps ----
      rd_ready = 0; wr_valid = 2'b11; wr_data0 = 8'h40; wr_data1 = 8'h80;
      nruns = 0; idle = 0; dbad = 0; prev_wr = 0; prev_adr = 2'b00;
      for (int k = 0; k < 4; k++) begin run_len[k] = 0; gap_before[k] = 0; run_adr[k] = 2'b00; end
      for (int c = 0; c < 260; c++) begin
         #1;
         if (FIFO_WR) begin
            if (!prev_wr || FIFO_FIFOADR != prev_adr) begin
               if (nruns < 4) begin
                  run_adr[nruns] = FIFO_FIFOADR;
                  gap_before[nruns] = idle;
               end
               nruns++;
            end
            if (nruns <= 4) run_len[nruns-1]++;
            if (FIFO_DATAOUT != ((FIFO_FIFOADR == 2'b10) ? 8'h40 : 8'h80)) dbad++;
            idle = 0;
         end else begin
            idle++;
         end
         prev_wr = FIFO_WR; prev_adr = FIFO_FIFOADR;
         @(negedge FIFO_clk);
      end
      check("burst_runs_seen", 32'(nruns >= 3), 32'd1);
      check("burst0_adr", 32'(run_adr[0]), 32'h2);
      check("burst1_adr", 32'(run_adr[1]), 32'h3);
      check("burst2_adr", 32'(run_adr[2]), 32'h2);
      check("burst0_len", 32'(run_len[0]), 32'd64);
      check("burst1_len", 32'(run_len[1]), 32'd64);
      check("burst2_len", 32'(run_len[2]), 32'd64);
      check("gap_0_1", 32'(gap_before[1]), 32'd2);
      check("gap_1_2", 32'(gap_before[2]), 32'd2);
      check("burst_dataout", 32'(dbad), 32'd0);

      // ---- single writer beyond MAX_BURST: no penalty cycles ----
      wr_valid = 2'b01;
      found = 0; waited = 0;
      while (!found && waited < 200) begin
         #1;
         if (FIFO_WR && FIFO_FIFOADR == 2'b10) found = 1;
         else begin waited++; @(negedge FIFO_clk); end
      end
      check("wr0_only_start", 32'(found), 32'd1);
      wrcnt = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge FIFO_clk); #1;
         if (FIFO_WR && FIFO_FIFOADR == 2'b10) wrcnt++;
      end
      check("saturate_no_gap", 32'(wrcnt), 32'd100);

      // ---- reset asserted mid-burst ----
      @(negedge FIFO_clk);
      reset = 1'b1;
      #1;
      check("midreset_outputs", 32'(act_vec()), 32'd0);
      @(negedge FIFO_clk);
      reset = 1'b0;
      wr_pat = '0; gnt3 = 2'b00;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (k == 0) check("post_reset_setup", 32'({grant, FIFO_FIFOADR, FIFO_DATAOUT_OE}), 32'd0);
         if (k == 3) gnt3 = grant;
         wr_pat[k] = FIFO_WR;
         @(negedge FIFO_clk);
      end
      check("post_reset_grant", 32'(gnt3), 32'd1);
      check("post_reset_wr_pattern", 32'(wr_pat), 32'b10000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fx2_fifo_arbiter.md
Name: fx2_fifo_arbiter

Overview:
- Sequences the shared FX2 slave-FIFO bus (FD, SLRD, SLWR, PKTEND, FIFOADR, OE) between three requesters:
  - command reader on FIFO2;
  - logic-analyzer capture writer on FIFO4;
  - status/response writer on FIFO5.
- Replaces the hardwired "always write FIFO4" assignments in the test harness.
- Handles address setup, bus turnaround, burst limiting, round-robin fairness and packet-end commits.
- All FIFO-side signals are active-high; the board-level wrapper inverts them.

Parameters:
- MAX_BURST, 64: transfers per grant before rotation is forced when another channel is eligible.
- BURST_W, 7: burst counter width; must be at least clog2(MAX_BURST+1).

Ports:
- FIFO_clk  in  1  system clock (FX2 IFCLK).
- reset  in  1  asynchronous, active-high.
- fifo2_empty  in  1  FIFO2 has no data.
- fifo4_full  in  1  FIFO4 cannot accept data this cycle.
- fifo5_full  in  1  FIFO5 cannot accept data this cycle.
- FIFO_DATAIN  in  8  FD bus input.
- FIFO_DATAOUT  out  8  FD bus drive value.
- FIFO_DATAOUT_OE  out  1  drive FD.
- FIFO_RD  out  1  slave read strobe.
- FIFO_WR  out  1  slave write strobe.
- FIFO_PKTEND  out  1  commit a short packet.
- FIFO_FIFOADR  out  2  FIFO select: 00 = FIFO2, 10 = FIFO4, 11 = FIFO5.
- rd_ready  in  1  command consumer can accept a byte.
- rd_data  out  8  received byte.
- rd_strobe  out  1  rd_data valid, one cycle.
- wr_valid  in  2  per write channel; [0] = FIFO4, [1] = FIFO5.
- wr_data0  in  8  channel 0 byte.
- wr_data1  in  8  channel 1 byte.
- wr_ready  out  2  byte consumed this cycle.
- pktend_req  in  2  level request; hold until ack.
- pktend_ack  out  2  one-cycle acknowledge.
- grant  out  2  current owner: 0 = read, 1 = wr0, 2 = wr1.

Behaviour:
- Reset (async):
  - State SETUP with grant = 0, FIFO_FIFOADR = 00.
  - All strobes and acks 0; FIFO_DATAOUT_OE = 0; FIFO_DATAOUT = 0; rd_data = 0; burst count = 0.
  - An in-flight request is dropped; pktend_req must still be held, and is served after reset.
- States:
  - SETUP (1 cycle): FIFOADR already set to the new owner; OE = 1 iff owner is a write channel; no strobes. Goes to XFER.
  - XFER:
    - Read owner: FIFO_RD = rd_ready & ~fifo2_empty (combinational). On each edge with FIFO_RD = 1, register FIFO_DATAIN into rd_data and pulse rd_strobe the next cycle (latency 1).
    - Write owner n: FIFO_WR = wr_ready[n] = wr_valid[n] & ~full[n]; FIFO_DATAOUT = wr_data_n (combinational mux). A byte is accepted on the edge where wr_ready is high.
    - If pktend_req[n] & ~wr_valid[n]: go to PKTEND. PKTEND is never issued in the same cycle as WR.
  - PKTEND (1 cycle): FIFO_PKTEND = 1, pktend_ack[n] = 1, no WR; then return to XFER.
  - TURN (1 cycle): all strobes 0, OE = 0, FIFOADR unchanged; then load the new owner and go to SETUP.
- Eligibility:
  - read: rd_ready & ~fifo2_empty.
  - wr n: (wr_valid[n] & ~full[n]) | pktend_req[n].
- Rotation (evaluated each XFER cycle, for the next edge):
  - Switch only if another channel is eligible AND (the owner is ineligible OR burst count = MAX_BURST).
  - New owner is the next eligible channel in round-robin order after the current owner (0 -> 1 -> 2 -> 0).
  - If nothing else is eligible, keep ownership; the burst count resets to 0 on saturation without a penalty cycle.
- Burst counter: increments on each RD/WR transfer; cleared on entry to SETUP; saturates at MAX_BURST.
- Switch penalty: exactly 2 idle bus cycles (TURN + SETUP) between the last strobe of the old owner and the first strobe of the new one.
- Full flag rising mid-burst: WR drops the same cycle, no byte is lost, and the channel becomes ineligible.
- Simultaneous pktend_req on both channels: each is served when its channel is granted, round-robin.

Decomposition:
- Shared package fx2_pkg:
  - FIFOADR codes FIFO2/4/5;
  - channel indices;
  - state encoding SETUP/XFER/PKTEND/TURN.
- Sub-module rr_pick3: combinational round-robin picker.
  - Inputs: 3-bit eligibility, 2-bit current owner.
  - Outputs: next owner, any_other.

Test Plan:
- Reset, then only wr_valid[0] held high with fifo4_full = 0:
  - FIFOADR 00 -> TURN -> SETUP with 10 -> FIFO_WR every cycle from cycle 3.
  - OE high from SETUP onward; bytes appear on FIFO_DATAOUT in order.
- wr0 and wr1 both continuously valid:
  - Bursts of exactly 64 WRs alternate between FIFOADR 10 and 11.
  - Exactly 2 strobe-free cycles between bursts.
- rd_ready = 1, FIFO2 holding 0xA5, 0x3C, then empty:
  - FIFO_RD for 2 cycles.
  - rd_strobe pulses 1 cycle later with 0xA5 then 0x3C.
  - OE is low throughout.
- wr0 streaming, then fifo4_full asserted for 5 cycles:
  - WR and wr_ready[0] are 0 for those exact 5 cycles.
  - No grant change when no other channel is eligible; the byte count is conserved.
- pktend_req[1] raised while wr1 sends 3 bytes:
  - 3 WRs, then 1 cycle with PKTEND = 1, WR = 0, pktend_ack[1] = 1.
  - Ack occurs exactly once.
- Reset asserted mid-write burst:
  - Outputs go immediately to their reset values (OE = 0, FIFOADR = 00).
  - After release, the arbiter resumes from SETUP with grant = 0.
